enc_seg_sequencer: RTL

Control FSM for the encoder's segmented thresholding stage. Steps the 2-bit segment select of the rearranged-level-HV multiplexer through all four 1024-dimension segments of a 4096-dimension encoding. For each segment it hands the selected 617-bit-per-dimension slice to the thresholder under a valid/ready handshake, waits for the result, and issues a write strobe so the encoded-HV register captures that segment. Sits between the encoder top-level control (start/done) and the segment mux / thresholder / output register.

---
 rtl/enc_pkg.sv | 18 +
 rtl/enc_seg_sequencer.sv | 87 ++++++++
 2 files changed

// File: rtl/enc_pkg.sv
// Shared encoder constants and the segment sequencer state type.
package enc_pkg;

    localparam int unsigned FEATURE_COUNT = 617;
    localparam int unsigned HV_DIM        = 4096;
    localparam int unsigned DIMS_PER_CC   = 1024;
    localparam int unsigned NUM_SEG       = HV_DIM / DIMS_PER_CC;
    localparam int unsigned SEG_W         = $clog2(NUM_SEG);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STORE,
        DONE
    } enc_seq_state_t;

endpackage

// File: rtl/enc_seg_sequencer.sv
// Steps the segment select through all encoder segments, handing each one to the
// thresholder and strobing the encoded-HV register once its result is back.
module enc_seg_sequencer
    import enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [SEG_W-1:0] ctr,
    output logic             seg_valid,
    input  logic             seg_ready,
    input  logic             res_valid,
    output logic             seg_wr_en,
    output logic [SEG_W-1:0] seg_wr_idx,
    output logic             err
);

    localparam logic [SEG_W-1:0] LastSeg = SEG_W'(NUM_SEG - 1);

    enc_seq_state_t   state_q, state_d;
    logic [SEG_W-1:0] ctr_q, ctr_d;
    logic             err_q, err_d;

    // Next-state decode; every output is a function of registered state only.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ctr_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (seg_ready) state_d = WAIT;
            end
            WAIT: begin
                if (res_valid) state_d = STORE;
            end
            STORE: begin
                if (ctr_q == LastSeg) begin
                    state_d = DONE;
                end else begin
                    ctr_d   = ctr_q + SEG_W'(1);
                    state_d = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A result outside WAIT is a protocol violation; an accepted start clears it.
        if (res_valid && (state_q != WAIT)) err_d = 1'b1;
        if ((state_q == IDLE) && start) err_d = 1'b0;

        busy       = (state_q != IDLE);
        seg_valid  = (state_q == ISSUE);
        seg_wr_en  = (state_q == STORE);
        done       = (state_q == DONE);
        ctr        = ctr_q;
        seg_wr_idx = ctr_q;
        err        = err_q;
    end

    // State, segment counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            err_q   <= err_d;
        end
    end

endmodule
